// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, framebuffer and control-state definitions
package vga_pkg;

   // 640x480@60 Hz horizontal timing, in pixels
   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

   // 640x480@60 Hz vertical timing, in lines
   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;

   localparam int FB_WORDS  = H_VISIBLE * V_VISIBLE;
   localparam int COLOR_W   = 9;
   localparam int ADDR_W    = 19;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_e;

   // 3-bit channel to 8-bit DAC value by bit replication (111 -> FF, 000 -> 00)
   function automatic logic [7:0] expand3(input logic [2:0] c);
      return {c, c, c[2:1]};
   endfunction

   // Linear framebuffer address row*640 + col, built from shifts only
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] col, input logic [8:0] row);
      logic [ADDR_W-1:0] r;
      r = ADDR_W'(row);
      return (r << 9) + (r << 7) + ADDR_W'(col);
   endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - pixel-write port between renderers and the scanout block
interface vga_scanout_if;
   import vga_pkg::*;

   logic [9:0]         x;
   logic [8:0]         y;
   logic [COLOR_W-1:0] color;
   logic               write;
   logic               ready;

   modport master (output x, y, color, write, input ready);
   modport slave  (input x, y, color, write, output ready);
endinterface

// File: rtl/fb_ram_sdp.sv
// rtl/fb_ram_sdp.sv - simple dual-port framebuffer RAM with registered read
module fb_ram_sdp #(
   parameter int DEPTH = 307200,
   parameter int WIDTH = 9,
   parameter int AW    = 19
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             re,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic             wr_ok;

   assign wr_ok   = we && (wr_addr < AW'(DEPTH));
   assign rd_data = rd_data_q;

   // No reset so the array maps onto block RAM; a same-address read returns old data
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_addr[IW-1:0]] <= wr_data;
      end
      if (re) begin
         rd_data_q <= mem[rd_addr[IW-1:0]];
      end
   end
endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - framebuffer owner: post-reset clear, pixel writes, VGA scanout
module vga_scanout
   import vga_pkg::*;
#(
   parameter logic [COLOR_W-1:0] BG_COLOR    = '0,
   parameter int                 VIS_LINES   = V_VISIBLE,
   parameter int                 VFP_LINES   = V_FP,
   parameter int                 VSYNC_LINES = V_SYNC,
   parameter int                 VBP_LINES   = V_BP
) (
   input  logic         CLOCK_50,
   input  logic         resetn,
   vga_scanout_if.slave pix,
   output logic         vsync_tick,
   output logic [7:0]   VGA_R,
   output logic [7:0]   VGA_G,
   output logic [7:0]   VGA_B,
   output logic         VGA_HS,
   output logic         VGA_VS,
   output logic         VGA_BLANK_N,
   output logic         VGA_SYNC_N,
   output logic         VGA_CLK
);
   localparam int              V_TOTAL_L = VIS_LINES + VFP_LINES + VSYNC_LINES + VBP_LINES;
   localparam int              FB_DEPTH  = H_VISIBLE * VIS_LINES;
   localparam logic [9:0]      H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]      H_VIS     = 10'(H_VISIBLE);
   localparam logic [9:0]      HS_START  = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0]      HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0]      V_LAST    = 10'(V_TOTAL_L - 1);
   localparam logic [9:0]      V_VIS     = 10'(VIS_LINES);
   localparam logic [9:0]      VS_START  = 10'(VIS_LINES + VFP_LINES);
   localparam logic [9:0]      VS_END    = 10'(VIS_LINES + VFP_LINES + VSYNC_LINES);
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_DEPTH - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic                ready_q, ready_d;
   logic                pix_en_q, pix_en_d;
   logic [9:0]          hc_q, hc_d, vc_q, vc_d;
   logic                vsync_tick_q, vsync_tick_d;
   logic                vis_p_q, vis_p_d, hs_p_q, hs_p_d, vs_p_q, vs_p_d;
   logic [7:0]          r_q, r_d, g_q, g_d, b_q, b_d;
   logic                hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

   logic                clearing, host_we, visible, wr_en;
   logic [ADDR_W-1:0]   wr_addr, rd_addr;
   logic [COLOR_W-1:0]  wr_data, rd_data;

   assign clearing = (state_q == S_CLEAR);
   assign host_we  = (state_q == S_RUN) && pix.write && (pix.x < H_VIS) && ({1'b0, pix.y} < V_VIS);
   assign wr_en    = clearing || host_we;
   assign wr_addr  = clearing ? clr_addr_q : pix_addr(pix.x, pix.y);
   assign wr_data  = clearing ? BG_COLOR : pix.color;
   assign visible  = (hc_q < H_VIS) && (vc_q < V_VIS);
   // Off-screen positions read address 0 so the RAM never sees an out-of-range index
   assign rd_addr  = visible ? pix_addr(hc_q, vc_q[8:0]) : '0;

   fb_ram_sdp #(.DEPTH(FB_DEPTH), .WIDTH(COLOR_W), .AW(ADDR_W)) u_fb (
      .clk     (CLOCK_50),
      .we      (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .re      (pix_en_q),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Clear sweep, raster counters and the two-stage scanout pipeline
   always_comb begin
      state_d      = state_q;
      clr_addr_d   = clr_addr_q;
      ready_d      = ready_q;
      pix_en_d     = ~pix_en_q;
      hc_d         = hc_q;
      vc_d         = vc_q;
      vsync_tick_d = 1'b0;
      vis_p_d      = vis_p_q;
      hs_p_d       = hs_p_q;
      vs_p_d       = vs_p_q;
      r_d          = r_q;
      g_d          = g_q;
      b_d          = b_q;
      hs_d         = hs_q;
      vs_d         = vs_q;
      blank_n_d    = blank_n_q;

      case (state_q)
         S_CLEAR: begin
            if (clr_addr_q == CLR_LAST) begin
               state_d = S_RUN;
               ready_d = 1'b1;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         S_RUN: ready_d = 1'b1;
         default: state_d = S_CLEAR;
      endcase

      if (pix_en_q) begin
         if (hc_q == H_LAST) begin
            hc_d         = '0;
            vc_d         = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
            vsync_tick_d = (vc_q == V_VIS - 10'd1);
         end else begin
            hc_d = hc_q + 10'd1;
         end
         // Stage 1: timing of the position whose read is issued this cycle
         vis_p_d   = visible;
         hs_p_d    = !((hc_q >= HS_START) && (hc_q < HS_END));
         vs_p_d    = !((vc_q >= VS_START) && (vc_q < VS_END));
         // Stage 2: RAM data (valid since last cycle) registered alongside its timing
         r_d       = vis_p_q ? expand3(rd_data[8:6]) : 8'h00;
         g_d       = vis_p_q ? expand3(rd_data[5:3]) : 8'h00;
         b_d       = vis_p_q ? expand3(rd_data[2:0]) : 8'h00;
         hs_d      = hs_p_q;
         vs_d      = vs_p_q;
         blank_n_d = vis_p_q;
      end
   end

   // All state registers; outputs only update as pix_en falls so the DAC edge sees stable data
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_CLEAR;
         clr_addr_q   <= '0;
         ready_q      <= 1'b0;
         pix_en_q     <= 1'b0;
         hc_q         <= '0;
         vc_q         <= '0;
         vsync_tick_q <= 1'b0;
         vis_p_q      <= 1'b0;
         hs_p_q       <= 1'b1;
         vs_p_q       <= 1'b1;
         r_q          <= '0;
         g_q          <= '0;
         b_q          <= '0;
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
         blank_n_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         ready_q      <= ready_d;
         pix_en_q     <= pix_en_d;
         hc_q         <= hc_d;
         vc_q         <= vc_d;
         vsync_tick_q <= vsync_tick_d;
         vis_p_q      <= vis_p_d;
         hs_p_q       <= hs_p_d;
         vs_p_q       <= vs_p_d;
         r_q          <= r_d;
         g_q          <= g_d;
         b_q          <= b_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         blank_n_q    <= blank_n_d;
      end
   end

   assign pix.ready   = ready_q;
   assign vsync_tick  = vsync_tick_q;
   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_SYNC_N  = 1'b0;
   assign VGA_CLK     = pix_en_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - self-checking bench for vga_scanout on a short-frame build
module tb_vga_scanout;
   import vga_pkg::*;

   localparam int VIS = 4, VFP = 2, VSY = 2, VBP = 2;
   localparam int LINE_CYC  = 2 * H_TOTAL;
   localparam int FRAME_CYC = LINE_CYC * (VIS + VFP + VSY + VBP);
   localparam int DEPTH     = H_VISIBLE * VIS;
   localparam logic [8:0] BG = 9'b001_010_011;
   localparam logic [23:0] BG_RGB = 24'h24496D;

   typedef struct { logic [9:0] x; logic [8:0] y; logic [8:0] color; logic wr; } wvec_t;
   typedef struct { logic [9:0] x; logic [8:0] y; logic [23:0] rgb; } probe_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #10 clk = ~clk;

   vga_scanout_if pif ();
   logic       vsync_tick, hs, vs, blank_n, sync_n, vclk;
   logic [7:0] r, g, b;

   vga_scanout #(.BG_COLOR(BG), .VIS_LINES(VIS), .VFP_LINES(VFP),
                 .VSYNC_LINES(VSY), .VBP_LINES(VBP)) dut (
      .CLOCK_50(clk), .resetn(resetn), .pix(pif.slave), .vsync_tick(vsync_tick),
      .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs),
      .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n), .VGA_CLK(vclk));

   int checks = 0;
   int errors = 0;
   probe_t sb[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic mon_en = 1'b0;
   logic hs_prev = 1'b1, vs_prev = 1'b1, bl_prev = 1'b0, tick_prev = 1'b0, pbl_prev = 1'b0;
   int hs_fall = -1, hs_rise = -1, vs_fall = -1, tick_last = -1;
   int hs_n = 0, bl_n = 0, tick_cnt = 0, vline = -100, px = 0;

   // Output monitor: sync geometry at cycle rate, pixel scoreboard once per pixel period
   always @(negedge clk) begin
      if (mon_en) begin
         if (hs_prev && !hs) begin
            if (hs_fall >= 0 && hs_n < 16) begin chk("hs_period", cyc - hs_fall, LINE_CYC); hs_n++; end
            hs_fall = cyc;
         end
         if (!hs_prev && hs) begin
            if (hs_fall >= 0 && hs_n < 16) chk("hs_width", cyc - hs_fall, 2 * H_SYNC);
            hs_rise = cyc;
         end
         if (!bl_prev && blank_n && hs_rise >= 0 && bl_n < 16) begin
            chk("hs_to_blank", cyc - hs_rise, 2 * H_BP);
            bl_n++;
         end
         if (vs_prev && !vs) begin
            if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, FRAME_CYC);
            vs_fall = cyc;
         end
         if (!vs_prev && vs && vs_fall >= 0) chk("vs_width", cyc - vs_fall, VSY * LINE_CYC);
         if (tick_prev) chk("tick_one_cycle", vsync_tick, 0);
         if (vsync_tick && !tick_prev) begin
            if (tick_last >= 0) chk("tick_spacing", cyc - tick_last, FRAME_CYC);
            tick_last = cyc;
            tick_cnt++;
         end
         if (vclk) begin
            if (!vs) vline = -1;
            if (blank_n && !pbl_prev) begin vline++; px = 0; end
            if (blank_n) begin
               if (sb.size() > 0 && int'(sb[0].x) == px && int'(sb[0].y) == vline) begin
                  chk($sformatf("pixel_%0d_%0d", px, vline), {r, g, b}, sb[0].rgb);
                  void'(sb.pop_front());
               end
               px++;
            end
            pbl_prev = blank_n;
         end
      end
      hs_prev = hs; vs_prev = vs; bl_prev = blank_n; tick_prev = vsync_tick;
   end

   task automatic wait_ready(output int n);
      logic done;
      n = 0;
      done = 1'b0;
      while (!done && n < 2 * DEPTH) begin
         if (n == 1000) begin
            pif.x = 10'd0; pif.y = 9'd0; pif.color = 9'h1FF; pif.write = 1'b1;
         end
         if (n == 1001) pif.write = 1'b0;
         @(posedge clk);
         n++;
         @(negedge clk);
         done = pif.ready;
      end
   endtask

   wvec_t  wv[6];
   probe_t pv[8];

   initial begin
      int n;
      wv[0] = '{10'd5,   9'd3, 9'b111_000_011, 1'b1};
      wv[1] = '{10'd640, 9'd0, 9'h1FF,         1'b1};
      wv[2] = '{10'd0,   9'd4, 9'h1FF,         1'b1};
      wv[3] = '{10'd1,   9'd0, 9'b010_101_001, 1'b1};
      wv[4] = '{10'd639, 9'd3, 9'b100_011_110, 1'b1};
      wv[5] = '{10'd6,   9'd3, 9'h1FF,         1'b0};
      pv[0] = '{10'd0,   9'd0, BG_RGB};
      pv[1] = '{10'd1,   9'd0, 24'h49B624};
      pv[2] = '{10'd0,   9'd1, BG_RGB};
      pv[3] = '{10'd5,   9'd2, BG_RGB};
      pv[4] = '{10'd4,   9'd3, BG_RGB};
      pv[5] = '{10'd5,   9'd3, 24'hFF006D};
      pv[6] = '{10'd6,   9'd3, BG_RGB};
      pv[7] = '{10'd639, 9'd3, 24'h926DDB};

      pif.x = '0; pif.y = '0; pif.color = '0; pif.write = 1'b0;
      resetn = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", pif.ready, 0);
      chk("rst_tick", vsync_tick, 0);
      chk("rst_r", r, 0);
      chk("rst_g", g, 0);
      chk("rst_b", b, 0);
      chk("rst_hs", hs, 1);
      chk("rst_vs", vs, 1);
      chk("rst_blank_n", blank_n, 0);
      chk("rst_vga_clk", vclk, 0);
      chk("rst_sync_n", sync_n, 0);

      resetn = 1'b1;
      repeat (DEPTH / 2) @(posedge clk);
      @(negedge clk);
      chk("ready_mid_clear", pif.ready, 0);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("ready_in_reset", pif.ready, 0);
      chk("vga_clk_in_reset", vclk, 0);
      resetn = 1'b1;
      mon_en = 1'b1;
      wait_ready(n);
      chk("clear_cycles", n, DEPTH);

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pif.x = wv[i].x; pif.y = wv[i].y; pif.color = wv[i].color; pif.write = wv[i].wr;
      end
      @(negedge clk);
      pif.write = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) sb.push_back(pv[i]);

      n = 0;
      while (sb.size() > 0 && n < 3 * FRAME_CYC) begin @(negedge clk); n++; end
      chk("probes_drained", sb.size(), 0);
      n = 0;
      while (tick_cnt < 3 && n < 4 * FRAME_CYC) begin @(negedge clk); n++; end
      chk("ticks_seen", (tick_cnt >= 3) ? 1 : 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
